// File: rtl/button_bank_if.sv
// button_bank_if: raw button inputs and conditioned per-channel outputs of a button_bank
interface button_bank_if #(
  parameter int CHANNELS = 4
);
  logic [CHANNELS-1:0] raw_in;
  logic [CHANNELS-1:0] clean_out;
  logic [CHANNELS-1:0] press_pulse;
  logic [CHANNELS-1:0] release_pulse;
  logic [CHANNELS-1:0] hold_pulse;
  logic [CHANNELS-1:0] repeat_pulse;
  modport master (
    output raw_in,
    input  clean_out, press_pulse, release_pulse, hold_pulse, repeat_pulse
  );
  modport slave (
    input  raw_in,
    output clean_out, press_pulse, release_pulse, hold_pulse, repeat_pulse
  );
endinterface

// File: rtl/button_bank.sv
// button_bank: per-channel synchronize, debounce and press/release/hold/repeat pulse generation
module button_bank #(
  parameter int CHANNELS        = 4,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int HOLD_CYCLES     = 50_000_000,
  parameter int REPEAT_CYCLES   = 10_000_000,
  parameter bit ACTIVE_LOW_IN   = 1'b0
) (
  input logic         clk,
  input logic         rst_n,
  button_bank_if.slave bus
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(HOLD_CYCLES);
  localparam int RW = $clog2(REPEAT_CYCLES + 1);
  localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] H_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [RW-1:0] R_LAST = RW'(REPEAT_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, PRESSED, HELD} state_t;
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic s1, s2, clean, rise, fall, hold_nx, rep_nx;
    logic press_q, release_q, hold_q, repeat_q;
    logic [DW-1:0] dcnt;
    logic [HW-1:0] hcnt, hcnt_nx;
    logic [RW-1:0] rcnt, rcnt_nx;
    state_t st, st_nx;
    assign rise = s2 && !clean && dcnt == D_LAST;
    assign fall = !s2 && clean && dcnt == D_LAST;
    always_comb begin
      st_nx   = st;
      hcnt_nx = hcnt;
      rcnt_nx = rcnt;
      hold_nx = 1'b0;
      rep_nx  = 1'b0;
      case (st)
        IDLE: begin
          st_nx   = rise ? PRESSED : IDLE;
          hcnt_nx = '0;
          rcnt_nx = '0;
          rep_nx  = rise;
        end
        PRESSED: begin
          if (fall) begin
            st_nx   = IDLE;
            hcnt_nx = '0;
          end else if (hcnt == H_LAST) begin
            st_nx   = HELD;
            rcnt_nx = '0;
            hold_nx = 1'b1;
            rep_nx  = 1'b1;
          end else begin
            hcnt_nx = hcnt + 1'b1;
          end
        end
        HELD: begin
          if (fall) begin
            st_nx   = IDLE;
            hcnt_nx = '0;
            rcnt_nx = '0;
          end else begin
            rcnt_nx = rcnt == R_LAST ? '0 : rcnt + 1'b1;
            rep_nx  = rcnt == R_LAST;
          end
        end
        default: st_nx = IDLE;
      endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1        <= 1'b0;
        s2        <= 1'b0;
        clean     <= 1'b0;
        dcnt      <= '0;
        hcnt      <= '0;
        rcnt      <= '0;
        st        <= IDLE;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        hold_q    <= 1'b0;
        repeat_q  <= 1'b0;
      end else begin
        s1        <= bus.raw_in[i] ^ ACTIVE_LOW_IN;
        s2        <= s1;
        clean     <= clean ^ (rise | fall);
        dcnt      <= (s2 == clean || rise || fall) ? '0 : dcnt + 1'b1;
        hcnt      <= hcnt_nx;
        rcnt      <= rcnt_nx;
        st        <= st_nx;
        press_q   <= rise;
        release_q <= fall;
        hold_q    <= hold_nx;
        repeat_q  <= rep_nx;
      end
    end
    assign bus.clean_out[i]     = clean;
    assign bus.press_pulse[i]   = press_q;
    assign bus.release_pulse[i] = release_q;
    assign bus.hold_pulse[i]    = hold_q;
    assign bus.repeat_pulse[i]  = repeat_q;
  end
endmodule

// File: tb/tb_button_bank.sv
// tb_button_bank: directed per-cycle checks of button_bank with D=4, H=20, R=5
module tb_button_bank;
  logic clk = 1'b0;
  logic rst_n;
  int tests = 0;
  int fails = 0;
  logic [19:0] obs;
  button_bank_if #(.CHANNELS(4)) bus ();
  button_bank #(
    .CHANNELS(4),
    .DEBOUNCE_CYCLES(4),
    .HOLD_CYCLES(20),
    .REPEAT_CYCLES(5),
    .ACTIVE_LOW_IN(1'b0)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );
  always #5 clk = ~clk;
  assign obs = {bus.clean_out, bus.press_pulse, bus.release_pulse, bus.hold_pulse, bus.repeat_pulse};
  task automatic check(input string tag, input logic [19:0] got, input logic [19:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [4:0] exp_ch(input int k, input int on, input int off);
    int tp, tr, h;
    logic cl, pr, re, ho, rp;
    if (on == 0) return 5'b0;
    tp = on + 5;
    tr = off + 6;
    h  = tp + 20;
    cl = k >= tp && k < tr;
    pr = k == tp;
    re = k == tr;
    ho = k == h && h < tr;
    rp = pr || (k >= h && k < tr && (k - h) % 5 == 0);
    return {cl, pr, re, ho, rp};
  endfunction
  task automatic run_scn(input string tag, input int on[4], input int off[4], input int n, input bit bounce);
    logic [3:0] r, e_cl, e_pr, e_re, e_ho, e_rp;
    logic [4:0] e;
    for (int k = 1; k <= n; k++) begin
      for (int c = 0; c < 4; c++) r[c] = on[c] != 0 && k >= on[c] && k <= off[c];
      if (bounce && k <= 30) r[0] = ((k - 1) / 3) % 2 == 0;
      bus.raw_in = r;
      @(posedge clk);
      #1;
      for (int c = 0; c < 4; c++) begin
        e = exp_ch(k, on[c], off[c]);
        {e_cl[c], e_pr[c], e_re[c], e_ho[c], e_rp[c]} = e;
      end
      check($sformatf("%s@%0d", tag, k), obs, {e_cl, e_pr, e_re, e_ho, e_rp});
    end
  endtask
  initial begin
    rst_n = 1'b0;
    bus.raw_in = 4'hF;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("in_reset@%0d", k), obs, '0);
    end
    rst_n = 1'b1;
    run_scn("reset_release", '{1, 1, 1, 1}, '{7, 7, 7, 7}, 16, 1'b0);
    run_scn("bounce", '{31, 0, 0, 0}, '{40, 0, 0, 0}, 50, 1'b1);
    run_scn("hold_repeat", '{0, 1, 0, 0}, '{0, 40, 0, 0}, 55, 1'b0);
    run_scn("release_on_hold", '{0, 0, 1, 0}, '{0, 0, 20, 0}, 32, 1'b0);
    run_scn("independence", '{1, 0, 0, 8}, '{29, 0, 0, 36}, 48, 1'b0);
    run_scn("pre_reset_hold", '{0, 1, 0, 0}, '{0, 60, 0, 0}, 30, 1'b0);
    #3 rst_n = 1'b0;
    #2 check("async_reset", obs, '0);
    @(posedge clk);
    #1;
    check("async_reset_held", obs, '0);
    rst_n = 1'b1;
    run_scn("re_press", '{0, 1, 0, 0}, '{0, 35, 0, 0}, 45, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
